// File: rtl/sram_arb.sv
// Two-port word arbiter/byte sequencer in front of a byte-wide async-SRAM controller.
// Latency: first m_go the cycle after grant; per byte ISSUE + busy time + 1; zero-strobe write acks 2 cycles after req.
// Backpressure: requests are held until ack; no grant while m_busy is high or during an ack cycle.
module sram_arb #(
    parameter int SRAM_AW    = 17,
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_req,
    input  logic               a_we,
    input  logic [SRAM_AW-3:0] a_adr,
    input  logic [3:0]         a_wstrb,
    input  logic [31:0]        a_wdata,
    output logic [31:0]        a_rdata,
    output logic               a_ack,
    input  logic               b_req,
    input  logic               b_we,
    input  logic [SRAM_AW-3:0] b_adr,
    input  logic [3:0]         b_wstrb,
    input  logic [31:0]        b_wdata,
    output logic [31:0]        b_rdata,
    output logic               b_ack,
    output logic               m_go,
    output logic               m_wr,
    output logic [SRAM_AW-1:0] m_adr,
    output logic [7:0]         m_dat,
    input  logic [7:0]         m_rdt,
    input  logic               m_busy
);
    localparam int WAW = SRAM_AW - 2;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO, ACK} state_t;

    state_t           state, state_nxt;
    logic             gnt_b, last_b, we, hi_cnt;
    logic [WAW-1:0]   adr;
    logic [31:0]      wdata, rbuf;
    logic [3:0]       mask;
    logic [1:0]       lane;

    logic             sel_b, sel_we, grant, lane_done;
    logic [WAW-1:0]   sel_adr, iss_adr;
    logic [31:0]      sel_wdata, iss_wdata;
    logic [3:0]       sel_wstrb, new_mask, mask_clr;
    logic [1:0]       iss_lane;
    logic             iss_we;

    function automatic logic [1:0] low_bit(input logic [3:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        if (m[2]) return 2'd2;
        return 2'd3;
    endfunction

    always_comb begin
        sel_b     = (FIXED_PRIO != 0) ? !a_req : ((a_req && b_req) ? !last_b : b_req);
        sel_we    = sel_b ? b_we    : a_we;
        sel_adr   = sel_b ? b_adr   : a_adr;
        sel_wstrb = sel_b ? b_wstrb : a_wstrb;
        sel_wdata = sel_b ? b_wdata : a_wdata;
        new_mask  = sel_we ? sel_wstrb : 4'b1111;
        // The ack cycle is excluded so a req still high during ack is not re-granted.
        grant     = (a_req || b_req) && !m_busy && !a_ack && !b_ack;
        mask_clr  = mask & ~(4'b0001 << lane);
        // A controller that never raises busy is treated as done after two WAIT_HI cycles.
        lane_done = (state == WAIT_LO && !m_busy) || (state == WAIT_HI && !m_busy && hi_cnt);
        iss_lane  = low_bit((state == IDLE) ? new_mask : mask_clr);
        iss_we    = (state == IDLE) ? sel_we    : we;
        iss_adr   = (state == IDLE) ? sel_adr   : adr;
        iss_wdata = (state == IDLE) ? sel_wdata : wdata;

        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = (new_mask == 4'b0000) ? ACK : ISSUE;
            ISSUE:   state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (m_busy)         state_nxt = WAIT_LO;
                else if (lane_done) state_nxt = (mask_clr != 4'b0000) ? ISSUE : ACK;
            end
            WAIT_LO: if (lane_done) state_nxt = (mask_clr != 4'b0000) ? ISSUE : ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    assign m_go = (state == ISSUE);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b  <= 1'b1;
            gnt_b   <= 1'b0;
            we      <= 1'b0;
            adr     <= '0;
            wdata   <= '0;
            rbuf    <= '0;
            mask    <= '0;
            lane    <= '0;
            hi_cnt  <= 1'b0;
            m_wr    <= 1'b0;
            m_adr   <= '0;
            m_dat   <= '0;
            a_rdata <= '0;
            b_rdata <= '0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
        end else begin
            a_ack  <= (state == ACK) && !gnt_b;
            b_ack  <= (state == ACK) &&  gnt_b;
            hi_cnt <= (state == WAIT_HI);
            if (state == ACK && !we) begin
                a_rdata <= rbuf;
                b_rdata <= rbuf;
            end
            if (state == IDLE && grant) begin
                gnt_b  <= sel_b;
                last_b <= sel_b;
                we     <= sel_we;
                adr    <= sel_adr;
                wdata  <= sel_wdata;
                mask   <= new_mask;
            end
            if (lane_done) begin
                if (!we) rbuf[{lane, 3'b000} +: 8] <= m_rdt;
                mask <= mask_clr;
            end
            if (state_nxt == ISSUE) begin
                lane  <= iss_lane;
                m_wr  <= iss_we;
                m_adr <= {iss_adr, iss_lane};
                m_dat <= iss_wdata[{iss_lane, 3'b000} +: 8];
            end
        end
    end
endmodule

// File: tb/tb_sram_arb.sv
// Bench for sram_arb: byte-SRAM controller model, directed vector table, corner sequences, random pairs vs reference.
module tb_sram_arb;
    typedef struct packed {
        logic        we;
        logic [14:0] adr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } txn_t;

    typedef struct packed {
        logic [16:0] adr;
        logic        wr;
        logic [7:0]  dat;
    } go_t;

    typedef struct {
        logic        port;
        txn_t        t;
        int          blen;
        int          ngo;
        logic [31:0] rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [14:0] a_adr = '0, b_adr = '0;
    logic [3:0]  a_wstrb = '0, b_wstrb = '0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [31:0] a_rdata, b_rdata;
    logic        a_ack, b_ack, m_go, m_wr;
    logic [16:0] m_adr;
    logic [7:0]  m_dat;
    logic [7:0]  m_rdt = 8'h00;
    logic        m_busy = 1'b0;

    logic        fa_req = 1'b0, fb_req = 1'b0;
    logic [31:0] fa_rdata, fb_rdata;
    logic        fa_ack, fb_ack, fm_go, fm_wr;
    logic [16:0] fm_adr;
    logic [7:0]  fm_dat;

    always #5 clk = ~clk;

    sram_arb #(.SRAM_AW(17), .FIXED_PRIO(0)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_adr(a_adr), .a_wstrb(a_wstrb), .a_wdata(a_wdata),
        .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_we(b_we), .b_adr(b_adr), .b_wstrb(b_wstrb), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ack(b_ack),
        .m_go(m_go), .m_wr(m_wr), .m_adr(m_adr), .m_dat(m_dat), .m_rdt(m_rdt), .m_busy(m_busy)
    );

    // Fixed-priority instance only ever sees zero-strobe writes, so it needs no SRAM.
    sram_arb #(.SRAM_AW(17), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .a_req(fa_req), .a_we(1'b1), .a_adr(15'h0), .a_wstrb(4'h0), .a_wdata(32'h0),
        .a_rdata(fa_rdata), .a_ack(fa_ack),
        .b_req(fb_req), .b_we(1'b1), .b_adr(15'h0), .b_wstrb(4'h0), .b_wdata(32'h0),
        .b_rdata(fb_rdata), .b_ack(fb_ack),
        .m_go(fm_go), .m_wr(fm_wr), .m_adr(fm_adr), .m_dat(fm_dat), .m_rdt(8'h00), .m_busy(1'b0)
    );

    // ---------------- controller model ----------------
    logic [7:0]  mem [0:4095];
    int          blen = 3, rise = 1;
    bit          ignore_go = 1'b0;
    logic        pl_vld = 1'b0;
    logic [11:0] pl_adr = '0;
    logic [7:0]  pl_dat = '0;
    int          dly = 0, bcnt = 0;
    logic [11:0] cur = '0;
    logic        cur_wr = 1'b0;

    always @(posedge clk) begin
        if (pl_vld) mem[pl_adr] <= pl_dat;
        if (dly != 0) begin
            dly <= dly - 1;
            if (dly == 1) begin m_busy <= 1'b1; bcnt <= blen; end
        end else if (m_busy) begin
            if (bcnt <= 1) begin
                m_busy <= 1'b0;
                if (!cur_wr) m_rdt <= mem[cur];
            end
            bcnt <= bcnt - 1;
        end else if (m_go && !ignore_go) begin
            cur    <= m_adr[11:0];
            cur_wr <= m_wr;
            if (m_wr) mem[m_adr[11:0]] <= m_dat;
            if (rise <= 1) begin m_busy <= 1'b1; bcnt <= blen; end
            else dly <= rise - 1;
        end
    end

    // ---------------- monitor ----------------
    go_t go_q[$];
    int  a_ack_cnt = 0, b_ack_cnt = 0, both_cnt = 0, go_busy_cnt = 0;

    always @(negedge clk) begin
        if (a_ack) a_ack_cnt <= a_ack_cnt + 1;
        if (b_ack) b_ack_cnt <= b_ack_cnt + 1;
        if (a_ack && b_ack) both_cnt <= both_cnt + 1;
        if (m_go && m_busy) go_busy_cnt <= go_busy_cnt + 1;
        if (m_go) go_q.push_back({m_adr, m_wr, (m_wr ? m_dat : 8'h00)});
    end

    // ---------------- reference + checking ----------------
    int          total = 0, bad = 0, go_rd = 0;
    go_t         exp_q[$];
    logic [7:0]  ref_mem [0:4095];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [14:0] adr, input logic [3:0] s, input logic [31:0] d);
        mk = {we, adr, s, d};
    endfunction

    function automatic logic [11:0] bidx(input logic [14:0] adr, input int l);
        bidx = {adr[9:0], 2'(l)};
    endfunction

    task automatic add_exp(input txn_t t);
        go_t g;
        for (int l = 0; l < 4; l++) begin
            if (!t.we || t.wstrb[l]) begin
                g.adr = {t.adr, 2'(l)};
                g.wr  = t.we;
                g.dat = t.we ? t.wdata[8*l +: 8] : 8'h00;
                exp_q.push_back(g);
            end
        end
    endtask

    task automatic ref_step(input txn_t t, inout logic [31:0] word);
        if (t.we) begin
            for (int l = 0; l < 4; l++)
                if (t.wstrb[l]) ref_mem[bidx(t.adr, l)] = t.wdata[8*l +: 8];
        end else begin
            for (int l = 0; l < 4; l++) word[8*l +: 8] = ref_mem[bidx(t.adr, l)];
        end
    endtask

    task automatic cmp_gos(input string nm);
        int n;
        n = go_q.size() - go_rd;
        chk({nm, " go count"}, 64'(n), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n; i++)
            chk({nm, " go"}, 64'(go_q[go_rd + i]), 64'(exp_q[i]));
        go_rd = go_q.size();
        exp_q.delete();
    endtask

    task automatic preload(input logic [11:0] adr, input logic [7:0] d);
        pl_adr = adr; pl_dat = d; pl_vld = 1'b1;
        ref_mem[adr] = d;
        @(posedge clk); #1;
        pl_vld = 1'b0;
    endtask

    task automatic run_pair(input bit use_a, input bit use_b, input txn_t ta, input txn_t tb_,
                            output bit first_b, output logic [31:0] ard, output logic [31:0] brd,
                            output bit to);
        bit done_a, done_b, got;
        int n;
        done_a = !use_a; done_b = !use_b; got = 1'b0; n = 0;
        first_b = 1'b0; ard = '0; brd = '0;
        if (use_a) begin a_we = ta.we; a_adr = ta.adr; a_wstrb = ta.wstrb; a_wdata = ta.wdata; a_req = 1'b1; end
        if (use_b) begin b_we = tb_.we; b_adr = tb_.adr; b_wstrb = tb_.wstrb; b_wdata = tb_.wdata; b_req = 1'b1; end
        while (!(done_a && done_b) && n < 3000) begin
            @(posedge clk); #1; n++;
            if (a_ack && !done_a) begin
                done_a = 1'b1; a_req = 1'b0; ard = a_rdata;
                if (!got) begin got = 1'b1; first_b = 1'b0; end
            end
            if (b_ack && !done_b) begin
                done_b = 1'b1; b_req = 1'b0; brd = b_rdata;
                if (!got) begin got = 1'b1; first_b = 1'b1; end
            end
        end
        to = (n >= 3000);
        a_req = 1'b0; b_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    vec_t        vt[8];
    bit          fb, to, last_b;
    logic [31:0] ard, brd, cur_word;

    initial begin
        int ac0, bc0, n;
        int ord[$], ford[$];
        txn_t t, ta, tb_;
        int mode;
        bit p0, p1, first_exp;
        logic [31:0] rd_a, rd_b;

        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;

        vt[0] = '{1'b0, mk(1'b0, 15'h100, 4'h0, 32'h0),        5, 4, 32'h44332211};
        vt[1] = '{1'b1, mk(1'b1, 15'h010, 4'hA, 32'hDEADBEEF), 3, 2, 32'h44332211};
        vt[2] = '{1'b1, mk(1'b0, 15'h010, 4'h0, 32'h0),        2, 4, 32'hDE03BE01};
        vt[3] = '{1'b0, mk(1'b1, 15'h020, 4'hF, 32'hCAFEF00D), 1, 4, 32'hDE03BE01};
        vt[4] = '{1'b0, mk(1'b0, 15'h020, 4'h0, 32'h0),        4, 4, 32'hCAFEF00D};
        vt[5] = '{1'b0, mk(1'b1, 15'h020, 4'h0, 32'h12345678), 3, 0, 32'hCAFEF00D};
        vt[6] = '{1'b1, mk(1'b1, 15'h020, 4'h1, 32'h000000AA), 2, 1, 32'hCAFEF00D};
        vt[7] = '{1'b1, mk(1'b0, 15'h020, 4'h0, 32'h0),        3, 4, 32'hCAFEF0AA};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_ack", 64'(a_ack), 0);
        chk("rst b_ack", 64'(b_ack), 0);
        chk("rst m_go", 64'(m_go), 0);
        chk("rst m_wr", 64'(m_wr), 0);
        chk("rst m_adr", 64'(m_adr), 0);
        chk("rst m_dat", 64'(m_dat), 0);
        chk("rst a_rdata", 64'(a_rdata), 0);
        chk("rst b_rdata", 64'(b_rdata), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Tie: both ports request continuously, zero-strobe writes
        a_we = 1'b1; a_wstrb = 4'h0; b_we = 1'b1; b_wstrb = 4'h0;
        a_req = 1'b1; b_req = 1'b1; fa_req = 1'b1; fb_req = 1'b1;
        n = 0;
        while ((ord.size() < 4 || ford.size() < 4) && n < 200) begin
            @(posedge clk); #1; n++;
            if (a_ack) ord.push_back(0);
            if (b_ack) ord.push_back(1);
            if (fa_ack) ford.push_back(0);
            if (fb_ack) ford.push_back(1);
            if (ord.size() >= 4) begin a_req = 1'b0; b_req = 1'b0; end
            if (ford.size() >= 4) begin fa_req = 1'b0; fb_req = 1'b0; end
        end
        a_req = 1'b0; b_req = 1'b0; fa_req = 1'b0; fb_req = 1'b0;
        chk("tie timeout", 64'(n >= 200), 0);
        for (int i = 0; i < 4 && i < ord.size(); i++) chk("rr grant order", 64'(ord[i]), 64'(i % 2));
        for (int i = 0; i < 4 && i < ford.size(); i++) chk("fixed grant order", 64'(ford[i]), 0);
        repeat (4) @(posedge clk);
        #1;
        cmp_gos("tie");

        // Zero-strobe latency
        a_we = 1'b1; a_wstrb = 4'h0; a_adr = 15'h7; a_req = 1'b1;
        n = 0;
        while (!a_ack && n < 20) begin @(posedge clk); #1; n++; end
        a_req = 1'b0;
        chk("zero-strobe ack latency", 64'(n), 2);
        repeat (3) @(posedge clk);
        #1;
        cmp_gos("zero-strobe");

        // Directed vector table
        preload(12'h400, 8'h11); preload(12'h401, 8'h22);
        preload(12'h402, 8'h33); preload(12'h403, 8'h44);
        preload(12'h040, 8'h01); preload(12'h042, 8'h03);
        cur_word = '0;
        for (int i = 0; i < 8; i++) begin
            blen = vt[i].blen; rise = 1 + (i % 2);
            ac0 = a_ack_cnt; bc0 = b_ack_cnt;
            run_pair(!vt[i].port, vt[i].port, vt[i].t, vt[i].t, fb, ard, brd, to);
            chk("vec timeout", 64'(to), 0);
            chk("vec rdata", 64'(vt[i].port ? brd : ard), 64'(vt[i].rd));
            chk("vec own ack", 64'(vt[i].port ? b_ack_cnt - bc0 : a_ack_cnt - ac0), 1);
            chk("vec other ack", 64'(vt[i].port ? a_ack_cnt - ac0 : b_ack_cnt - bc0), 0);
            chk("vec go count", 64'(go_q.size() - go_rd), 64'(vt[i].ngo));
            add_exp(vt[i].t);
            cmp_gos("vec");
            ref_step(vt[i].t, cur_word);
        end
        chk("sparse 0x40 untouched", 64'(mem[12'h040]), 64'h01);
        chk("sparse 0x41", 64'(mem[12'h041]), 64'hBE);
        chk("sparse 0x42 untouched", 64'(mem[12'h042]), 64'h03);
        chk("sparse 0x43", 64'(mem[12'h043]), 64'hDE);

        // Reset during the second byte of an A read
        blen = 5; rise = 1;
        t = mk(1'b0, 15'h100, 4'h0, 32'h0);
        ac0 = a_ack_cnt;
        a_we = t.we; a_adr = t.adr; a_wstrb = t.wstrb; a_wdata = t.wdata; a_req = 1'b1;
        n = 0;
        while (!((go_q.size() - go_rd) >= 2 && m_busy) && n < 200) begin @(posedge clk); #1; n++; end
        chk("midrst reach byte2", 64'(n >= 200), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst m_go low", 64'(m_go), 0);
        chk("midrst a_rdata cleared", 64'(a_rdata), 0);
        rst = 1'b0;
        n = 0;
        while (m_busy && n < 50) begin @(posedge clk); #1; n++; end
        chk("midrst no go while busy", 64'(go_q.size() - go_rd), 2);
        run_pair(1'b1, 1'b0, t, t, fb, ard, brd, to);
        chk("midrst timeout", 64'(to), 0);
        chk("midrst single ack", 64'(a_ack_cnt - ac0), 1);
        chk("midrst rdata", 64'(ard), 64'h44332211);
        exp_q.push_back({17'h400, 1'b0, 8'h00});
        exp_q.push_back({17'h401, 1'b0, 8'h00});
        add_exp(t);
        cmp_gos("midrst");
        cur_word = 32'h44332211;
        last_b = 1'b0;

        // Random pairs vs reference
        for (int it = 0; it < 40; it++) begin
            mode = $urandom_range(0, 2);
            ta  = mk(1'($urandom_range(0, 1)), 15'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom);
            tb_ = mk(1'($urandom_range(0, 1)), 15'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), $urandom);
            blen = $urandom_range(1, 4); rise = $urandom_range(1, 2);
            first_exp = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : !last_b;
            run_pair(mode != 1, mode != 0, ta, tb_, fb, ard, brd, to);
            chk("rand timeout", 64'(to), 0);
            if (mode == 2) chk("rand rr first", 64'(fb), 64'(first_exp));
            p0 = first_exp; p1 = !first_exp;
            rd_a = '0; rd_b = '0;
            add_exp(p0 ? tb_ : ta);
            ref_step(p0 ? tb_ : ta, cur_word);
            if (p0) rd_b = cur_word; else rd_a = cur_word;
            last_b = p0;
            if (mode == 2) begin
                add_exp(p1 ? tb_ : ta);
                ref_step(p1 ? tb_ : ta, cur_word);
                if (p1) rd_b = cur_word; else rd_a = cur_word;
                last_b = p1;
            end
            if (mode != 1) chk("rand a_rdata", 64'(ard), 64'(rd_a));
            if (mode != 0) chk("rand b_rdata", 64'(brd), 64'(rd_b));
            cmp_gos("rand");
        end

        // Controller that never raises busy
        ignore_go = 1'b1;
        ac0 = a_ack_cnt;
        t = mk(1'b0, 15'h100, 4'h0, 32'h0);
        run_pair(1'b1, 1'b0, t, t, fb, ard, brd, to);
        chk("nobusy timeout", 64'(to), 0);
        chk("nobusy ack", 64'(a_ack_cnt - ac0), 1);
        add_exp(t);
        cmp_gos("nobusy");
        ignore_go = 1'b0;

        chk("go while busy", 64'(go_busy_cnt), 0);
        chk("both acks together", 64'(both_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
